data_merge_sync: RTL and testbench

DATA_MERGE_SYNC -- requirements
Module: data_merge_sync

---
 rtl/data_merge_pkg.sv | 28 ++
 rtl/data_merge_sync_sync_ff.sv | 24 ++
 rtl/data_merge_sync.sv | 138 +++++++++++++
 tb/tb_data_merge_sync.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/data_merge_pkg.sv
// Shared types and defaults for the two-producer handshake merge block.
package data_merge_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    typedef enum logic {
        CH1 = 1'b0,
        CH2 = 1'b1
    } chan_t;

    // Round-robin pick: a contested cycle goes to the channel not served last,
    // otherwise whichever channel is pending wins.
    function automatic chan_t rr_pick(input logic pend1, input logic pend2, input chan_t last);
        if (pend1 && pend2) begin
            return (last == CH1) ? CH2 : CH1;
        end else if (pend2) begin
            return CH2;
        end
        return CH1;
    endfunction

endpackage

// File: rtl/data_merge_sync_sync_ff.sv
// Single-bit flop-chain synchronizer with synchronous clear.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the chain; clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/data_merge_sync.sv
// Two-producer, one-consumer two-phase handshake merge with round-robin
// arbitration and synchronized handshake inputs.
// Optional build macro DATA_MERGE_SYNC_TAG_EN adds out_src, the source
// channel of the word currently on out (0 = channel 1, 1 = channel 2).
module data_merge_sync
    import data_merge_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l1_req,
    input  logic             l2_req,
    output logic             l1_ack,
    output logic             l2_ack,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             r_req,
    input  logic             r_ack,
    output logic [WIDTH-1:0] out
`ifdef DATA_MERGE_SYNC_TAG_EN
    ,
    output logic             out_src
`endif
);

    logic w_l1_req_s;
    logic w_l2_req_s;
    logic w_r_ack_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_l1 (.clk(clk), .rst(rst), .i_d(l1_req), .o_q(w_l1_req_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_l2 (.clk(clk), .rst(rst), .i_d(l2_req), .o_q(w_l2_req_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ra (.clk(clk), .rst(rst), .i_d(r_ack),  .o_q(w_r_ack_s));

    state_t           r_state, r_state_next;
    logic [WIDTH-1:0] r_out, r_out_next;
    logic             r_rreq, r_rreq_next;
    logic             r_l1_ack, r_l1_ack_next;
    logic             r_l2_ack, r_l2_ack_next;
    chan_t            r_served, r_served_next;
    chan_t            r_last, r_last_next;

    logic  w_pend1;
    logic  w_pend2;
    logic  w_launch;
    logic  w_done;
    chan_t w_sel;

    // A channel is pending while its synchronized request phase leads its ack.
    assign w_pend1  = w_l1_req_s ^ r_l1_ack;
    assign w_pend2  = w_l2_req_s ^ r_l2_ack;
    assign w_sel    = rr_pick(w_pend1, w_pend2, r_last);
    assign w_launch = (r_state == IDLE) && (w_pend1 || w_pend2);
    assign w_done   = (r_state == WAIT_ACK) && (w_r_ack_s == r_rreq);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // Next-state logic: one transfer in flight at a time.
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            IDLE:     if (w_launch) r_state_next = WAIT_ACK;
            WAIT_ACK: if (w_done)   r_state_next = IDLE;
            default:  r_state_next = IDLE;
        endcase
    end

    // Output logic: launch captures data and flips r_req; completion acks the served producer.
    always_comb begin
        r_out_next    = r_out;
        r_rreq_next   = r_rreq;
        r_l1_ack_next = r_l1_ack;
        r_l2_ack_next = r_l2_ack;
        r_served_next = r_served;
        r_last_next   = r_last;
        if (w_launch) begin
            r_out_next    = (w_sel == CH2) ? in_2 : in_1;
            r_rreq_next   = !r_rreq;
            r_served_next = w_sel;
        end
        if (w_done) begin
            if (r_served == CH2) begin
                r_l2_ack_next = !r_l2_ack;
            end else begin
                r_l1_ack_next = !r_l1_ack;
            end
            r_last_next = r_served;
        end
    end

    // Datapath and handshake registers; last-served resets to channel 2 so channel 1 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_rreq   <= 1'b0;
            r_l1_ack <= 1'b0;
            r_l2_ack <= 1'b0;
            r_served <= CH1;
            r_last   <= CH2;
        end else begin
            r_out    <= r_out_next;
            r_rreq   <= r_rreq_next;
            r_l1_ack <= r_l1_ack_next;
            r_l2_ack <= r_l2_ack_next;
            r_served <= r_served_next;
            r_last   <= r_last_next;
        end
    end

`ifdef DATA_MERGE_SYNC_TAG_EN
    logic r_src;

    // Source tag captured on the same cycle as out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src <= 1'b0;
        end else if (w_launch) begin
            r_src <= (w_sel == CH2);
        end
    end

    assign out_src = r_src;
`endif

    assign out    = r_out;
    assign r_req  = r_rreq;
    assign l1_ack = r_l1_ack;
    assign l2_ack = r_l2_ack;

endmodule

// File: tb/tb_data_merge_sync.sv
// Directed and scoreboarded checks for data_merge_sync (WIDTH=8, SYNC_STAGES=2).
module tb_data_merge_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       l1_req, l2_req, r_ack;
    logic       l1_ack, l2_ack, r_req;
    logic [7:0] in_1, in_2, out;
`ifdef DATA_MERGE_SYNC_TAG_EN
    logic       out_src;
`endif

    data_merge_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .l1_req(l1_req), .l2_req(l2_req),
        .l1_ack(l1_ack), .l2_ack(l2_ack),
        .in_1(in_1), .in_2(in_2),
        .r_req(r_req), .r_ack(r_ack),
        .out(out)
`ifdef DATA_MERGE_SYNC_TAG_EN
        , .out_src(out_src)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       e_l1, e_l2, e_rreq, e_src;
    logic [7:0] e_out;

    logic [7:0] q1[$];
    logic [7:0] q2[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_all(input string tag);
        chk({tag, ".out"},    out,    e_out);
        chk({tag, ".r_req"},  r_req,  e_rreq);
        chk({tag, ".l1_ack"}, l1_ack, e_l1);
        chk({tag, ".l2_ack"}, l2_ack, e_l2);
`ifdef DATA_MERGE_SYNC_TAG_EN
        chk({tag, ".src"},    out_src, e_src);
`endif
        $display("txn %s: out=%02h r_req=%0b l1_ack=%0b l2_ack=%0b", tag, out, r_req, l1_ack, l2_ack);
    endtask

    task automatic do_reset();
        rst = 1'b1; l1_req = 1'b0; l2_req = 1'b0; r_ack = 1'b0;
        step(3);
        rst = 1'b0;
        e_l1 = 0; e_l2 = 0; e_rreq = 0; e_out = 8'h00; e_src = 0;
    endtask

    initial begin
        rst = 1'b1; l1_req = 1'b0; l2_req = 1'b0; r_ack = 1'b0; in_1 = 8'h00; in_2 = 8'h00;
        step(3);
        e_l1 = 0; e_l2 = 0; e_rreq = 0; e_out = 8'h00; e_src = 0;
        expect_all("reset");
        rst = 1'b0;
        step(1);

        // Single transfer with latency boundaries.
        in_1 = 8'hA5; l1_req = 1'b1;
        step(2); chk("single.early", r_req, 1'b0);
        step(1); e_rreq = 1; e_out = 8'hA5; e_src = 0; expect_all("single.req");
        r_ack = 1'b1;
        step(2); chk("single.ack_early", l1_ack, 1'b0);
        step(1); e_l1 = 1; expect_all("single.ack");

        // Simultaneous pair after reset: channel 1 first.
        do_reset();
        step(1);
        in_1 = 8'h11; in_2 = 8'h22; l1_req = 1'b1; l2_req = 1'b1;
        step(3); e_rreq = 1; e_out = 8'h11; e_src = 0; expect_all("pair1.first");
        r_ack = 1'b1;
        step(3); e_l1 = 1; expect_all("pair1.ack1");
        step(1); e_rreq = 0; e_out = 8'h22; e_src = 1; expect_all("pair1.second");
        r_ack = 1'b0;
        step(3); e_l2 = 1; expect_all("pair1.ack2");

        // Lone channel 1 transfer leaves channel 1 as last served.
        in_1 = 8'h55; l1_req = 1'b0;
        step(3); e_rreq = 1; e_out = 8'h55; e_src = 0; expect_all("single2.req");
        r_ack = 1'b1;
        step(3); e_l1 = 0; expect_all("single2.ack");

        // Next simultaneous pair: channel 2 first.
        in_1 = 8'h33; in_2 = 8'h44; l1_req = 1'b1; l2_req = 1'b0;
        step(3); e_rreq = 0; e_out = 8'h44; e_src = 1; expect_all("pair2.first");
        r_ack = 1'b0;
        step(3); e_l2 = 0; expect_all("pair2.ack2");
        step(1); e_rreq = 1; e_out = 8'h33; e_src = 0; expect_all("pair2.second");
        r_ack = 1'b1;
        step(3); e_l1 = 1; expect_all("pair2.ack1");

        // Back-pressure: consumer stalls while channel 2 toggles.
        in_1 = 8'h66; l1_req = 1'b0;
        step(3); e_rreq = 0; e_out = 8'h66; e_src = 0; expect_all("bp.req");
        in_2 = 8'h77; l2_req = 1'b1;
        step(20); expect_all("bp.hold");
        r_ack = 1'b0;
        step(3); e_l1 = 0; expect_all("bp.ack1");
        step(1); e_rreq = 1; e_out = 8'h77; e_src = 1; expect_all("bp.ch2");
        r_ack = 1'b1;
        step(3); e_l2 = 1; expect_all("bp.ack2");

        // Reset while waiting for the consumer; held l1_req is re-served.
        in_1 = 8'h88; l1_req = 1'b1;
        step(3); e_rreq = 0; e_out = 8'h88; e_src = 0; expect_all("rst.req");
        rst = 1'b1; l2_req = 1'b0; r_ack = 1'b0;
        step(1); e_l1 = 0; e_l2 = 0; e_rreq = 0; e_out = 8'h00; e_src = 0; expect_all("rst.clear");
        rst = 1'b0;
        step(2); expect_all("rst.early");
        step(1); e_rreq = 1; e_out = 8'h88; expect_all("rst.reserve");
        r_ack = 1'b1;
        step(3); e_l1 = 1; expect_all("rst.ack");

        // Random traffic: data bit 7 marks the producer, per-channel order checked.
        do_reset();
        step(1);
        fork
            begin : prod1
                for (int i = 0; i < 100; i++) begin
                    logic [7:0] d;
                    int cnt;
                    d = {1'b0, 7'($urandom)};
                    in_1 = d;
                    q1.push_back(d);
                    l1_req = !l1_req;
                    cnt = 0;
                    while (l1_ack != l1_req && cnt < 2000) begin
                        step(1);
                        cnt++;
                    end
                    chk("rnd.p1_ack", l1_ack, l1_req);
                    if (l1_ack != l1_req) break;
                    step($urandom_range(3, 0));
                end
            end
            begin : prod2
                for (int i = 0; i < 100; i++) begin
                    logic [7:0] d;
                    int cnt;
                    d = {1'b1, 7'($urandom)};
                    in_2 = d;
                    q2.push_back(d);
                    l2_req = !l2_req;
                    cnt = 0;
                    while (l2_ack != l2_req && cnt < 2000) begin
                        step(1);
                        cnt++;
                    end
                    chk("rnd.p2_ack", l2_ack, l2_req);
                    if (l2_ack != l2_req) break;
                    step($urandom_range(3, 0));
                end
            end
            begin : cons
                for (int n = 0; n < 200; n++) begin
                    logic [7:0] want;
                    int cnt;
                    cnt = 0;
                    while (r_req == r_ack && cnt < 2000) begin
                        step(1);
                        cnt++;
                    end
                    chk("rnd.req_wait", r_req, !r_ack);
                    if (r_req == r_ack) break;
                    want = 8'hxx;
                    if (out[7] == 1'b0 && q1.size() > 0) want = q1.pop_front();
                    else if (out[7] == 1'b1 && q2.size() > 0) want = q2.pop_front();
                    chk("rnd.data", out, want);
`ifdef DATA_MERGE_SYNC_TAG_EN
                    chk("rnd.src", out_src, out[7]);
`endif
                    $display("txn rnd[%0d]: out=%02h", n, out);
                    step($urandom_range(4, 0));
                    r_ack = !r_ack;
                end
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
